// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and constants for the UART word receiver.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int OS_RATE           = 16;
    localparam int OS_MID            = 7;
    localparam int DEFAULT_BAUD_DIV  = 27;
    localparam int DEFAULT_GAP_TICKS = 512;

    // Non-zero when the received parity bit disagrees with the data bits.
    function automatic logic parity_fail(input logic [7:0] data,
                                         input logic       pbit,
                                         input logic       odd);
        return (^data) ^ pbit ^ odd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tick_gen.sv
// ============================================================================
// Module   : uart_tick_gen
// Brief    : Divides clk down to the 16x oversample tick; restartable.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tick_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int              c_cnt_w = $clog2(BAUD_DIV);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(BAUD_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (restart || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/uart_word_receiver.sv
// ============================================================================
// Module   : uart_word_receiver
// Brief    : 16x-oversampled UART receiver pairing good bytes into 16-bit words.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_word_receiver
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0,
    parameter int GAP_TICKS  = DEFAULT_GAP_TICKS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_in,
    output logic [15:0] rx_word,
    output logic        rx_valid,
    output logic        ferror,
    output logic        perror,
    output logic        busy
);

    localparam int                 c_gap_w   = $clog2(GAP_TICKS + 1);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_TICKS - 1);
    localparam logic [3:0]         c_os_mid   = 4'(OS_MID);
    localparam logic [3:0]         c_os_last  = 4'(OS_RATE - 1);

    logic               r_sync1, r_sync2, r_rxs_d, r_fall;
    rx_state_t          r_state;
    logic [3:0]         r_os;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_pbit;
    logic               r_phase;
    logic [7:0]         r_hi;
    logic [c_gap_w-1:0] r_gap;
    logic [15:0]        r_word;
    logic               r_valid, r_ferror, r_perror;

    logic w_tick, w_rxs, w_start, w_perr;

    assign w_rxs   = r_sync2;
    assign w_start = (r_state == ST_IDLE) && r_fall;
    assign w_perr  = PARITY_EN ? parity_fail(r_shift, r_pbit, PARITY_ODD) : 1'b0;

    uart_tick_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .restart (w_start),
        .tick    (w_tick)
    );

    // Falling edge is registered so an edge coinciding with the stop sample
    // is still seen once the FSM is back in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rxs_d <= 1'b1;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
            r_rxs_d <= r_sync2;
            r_fall  <= r_rxs_d & ~r_sync2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_os     <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_pbit   <= 1'b0;
            r_phase  <= 1'b0;
            r_hi     <= '0;
            r_gap    <= '0;
            r_word   <= '0;
            r_valid  <= 1'b0;
            r_ferror <= 1'b0;
            r_perror <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if ((r_state != ST_IDLE) || !r_phase) begin
                r_gap <= '0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (r_fall) begin
                        r_state <= ST_START;
                        r_os    <= '0;
                    end else if (r_phase && w_tick) begin
                        if (r_gap == c_gap_last) begin
                            r_phase <= 1'b0;
                            r_gap   <= '0;
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (r_os == c_os_mid) begin
                            r_os  <= '0;
                            r_bit <= '0;
                            r_state <= w_rxs ? ST_IDLE : ST_DATA;
                        end else begin
                            r_os <= r_os + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_os == c_os_last) begin
                            r_os    <= '0;
                            r_shift <= {w_rxs, r_shift[7:1]};
                            r_bit   <= r_bit + 1'b1;
                            if (r_bit == 3'd7) begin
                                r_state <= PARITY_EN ? ST_PARITY : ST_STOP;
                            end
                        end else begin
                            r_os <= r_os + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        if (r_os == c_os_last) begin
                            r_os    <= '0;
                            r_pbit  <= w_rxs;
                            r_state <= ST_STOP;
                        end else begin
                            r_os <= r_os + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (r_os == c_os_last) begin
                            r_os     <= '0;
                            r_state  <= ST_IDLE;
                            r_ferror <= ~w_rxs;
                            r_perror <= w_perr;
                            if (w_rxs && !w_perr) begin
                                if (r_phase) begin
                                    r_word  <= {r_hi, r_shift};
                                    r_valid <= 1'b1;
                                    r_phase <= 1'b0;
                                end else begin
                                    r_hi    <= r_shift;
                                    r_phase <= 1'b1;
                                end
                            end else begin
                                r_phase <= 1'b0;
                            end
                        end else begin
                            r_os <= r_os + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rx_word  = r_word;
    assign rx_valid = r_valid;
    assign ferror   = r_ferror;
    assign perror   = r_perror;
    assign busy     = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_word_receiver.sv
// ============================================================================
// Module   : tb_uart_word_receiver
// Brief    : Directed scoreboard bench for uart_word_receiver at BAUD_DIV=4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_word_receiver;

    localparam int BAUD_DIV = 4;
    localparam int BIT_CYC  = 16 * BAUD_DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_in = 1'b1;
    logic [15:0] rx_word;
    logic        rx_valid, ferror, perror, busy;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];

    uart_word_receiver #(
        .BAUD_DIV   (BAUD_DIV),
        .PARITY_EN  (1'b1),
        .PARITY_ODD (1'b0),
        .GAP_TICKS  (512)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_in    (rx_in),
        .rx_word  (rx_word),
        .rx_valid (rx_valid),
        .ferror   (ferror),
        .perror   (perror),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        rx_in = v;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop, input bit bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((^b) ^ bad_par);
        send_bit(~bad_stop);
        rx_in = 1'b1;
    endtask

    task automatic send_word(input logic [15:0] w);
        exp_q.push_back(w);
        send_byte(w[15:8], 1'b0, 1'b0);
        send_byte(w[7:0], 1'b0, 1'b0);
    endtask

    task automatic idle_bits(input int n);
        rx_in = 1'b1;
        repeat (n * BIT_CYC) @(negedge clk);
    endtask

    // Scoreboard: every rx_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (reset && rx_valid) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_valid observed=%h expected=none", rx_word);
            end
            if (exp_q.size() != 0) chk("rx_word_sb", rx_word, exp_q.pop_front());
        end
    end

    initial begin
        reset = 1'b0;
        rx_in = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_word", rx_word, 16'h0000);
        chk("rst_valid", {15'd0, rx_valid}, 16'h0000);
        chk("rst_ferror", {15'd0, ferror}, 16'h0000);
        chk("rst_perror", {15'd0, perror}, 16'h0000);
        chk("rst_busy", {15'd0, busy}, 16'h0000);

        // Good word
        send_word(16'h1234);
        idle_bits(1);
        chk("w1234_word", rx_word, 16'h1234);
        chk("w1234_ferror", {15'd0, ferror}, 16'h0000);
        chk("w1234_perror", {15'd0, perror}, 16'h0000);
        chk("w1234_q", 16'(exp_q.size()), 16'h0000);

        // Bad stop bit on second byte
        send_byte(8'hAB, 1'b0, 1'b0);
        send_byte(8'hCD, 1'b1, 1'b0);
        idle_bits(1);
        chk("badstop_ferror", {15'd0, ferror}, 16'h0001);
        chk("badstop_perror", {15'd0, perror}, 16'h0000);
        chk("badstop_word", rx_word, 16'h1234);
        send_word(16'h5678);
        idle_bits(1);
        chk("w5678_word", rx_word, 16'h5678);
        chk("w5678_ferror", {15'd0, ferror}, 16'h0000);
        chk("w5678_q", 16'(exp_q.size()), 16'h0000);

        // Start glitch of 3 ticks
        rx_in = 1'b0;
        repeat (3 * BAUD_DIV) @(negedge clk);
        rx_in = 1'b1;
        repeat (8) @(negedge clk);
        chk("glitch_busy_hi", {15'd0, busy}, 16'h0001);
        repeat (60) @(negedge clk);
        chk("glitch_busy_lo", {15'd0, busy}, 16'h0000);
        chk("glitch_ferror", {15'd0, ferror}, 16'h0000);
        chk("glitch_perror", {15'd0, perror}, 16'h0000);

        // Parity error drops the half-assembled word
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b1);
        idle_bits(1);
        chk("par_perror", {15'd0, perror}, 16'h0001);
        chk("par_ferror", {15'd0, ferror}, 16'h0000);
        send_word(16'h3344);
        idle_bits(1);
        chk("w3344_word", rx_word, 16'h3344);
        chk("w3344_perror", {15'd0, perror}, 16'h0000);
        chk("w3344_q", 16'(exp_q.size()), 16'h0000);

        // Gap timeout: 600 idle ticks exceed the 512-tick limit
        send_byte(8'h9A, 1'b0, 1'b0);
        rx_in = 1'b1;
        repeat (600 * BAUD_DIV) @(negedge clk);
        send_word(16'hBCDE);
        idle_bits(1);
        chk("gap_word", rx_word, 16'hBCDE);
        chk("gap_q", 16'(exp_q.size()), 16'h0000);

        // Reset during data bit 4 of the second byte
        send_byte(8'h55, 1'b0, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx_in = 1'b0;
        repeat (30) @(negedge clk);
        chk("mid_busy", {15'd0, busy}, 16'h0001);
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_word", rx_word, 16'h0000);
        chk("mrst_valid", {15'd0, rx_valid}, 16'h0000);
        chk("mrst_ferror", {15'd0, ferror}, 16'h0000);
        chk("mrst_perror", {15'd0, perror}, 16'h0000);
        chk("mrst_busy", {15'd0, busy}, 16'h0000);
        rx_in = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        idle_bits(1);
        send_word(16'h0F0F);
        idle_bits(1);
        chk("w0f0f_word", rx_word, 16'h0F0F);
        chk("w0f0f_q", 16'(exp_q.size()), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
